// File: rtl/md_pkg.sv
// Shared types and op-select bit positions for the multiply/divide HI/LO unit.
package md_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   // Bit positions inside the decoder's one-hot pairs
   localparam int SEL_S = 0;   // MULT / DIV (signed)
   localparam int SEL_U = 1;   // MULTU / DIVU (unsigned)
   localparam int HL_LO = 0;   // MTLO / MFLO
   localparam int HL_HI = 1;   // MTHI / MFHI

   // A pair with both bits set falls back to the unsigned variant
   function automatic logic pair_signed(input logic [1:0] pair);
      return pair[SEL_S] & ~pair[SEL_U];
   endfunction

endpackage

// File: rtl/md_hilo_unit_if.sv
// EX-stage bundle between the pipeline (master) and the mul/div HI/LO unit (slave).
interface md_hilo_unit_if #(
   parameter int DATA_W = 32
);
   logic              op_valid;
   logic [1:0]        mult;
   logic [1:0]        div;
   logic [1:0]        mthl;
   logic [1:0]        mfhl;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              flush;
   logic              stall;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hl_rdata;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (
      output op_valid, mult, div, mthl, mfhl, src_a, src_b, flush,
      input  stall, busy, done, hl_rdata, hi, lo
   );

   modport slave (
      input  op_valid, mult, div, mthl, mfhl, src_a, src_b, flush,
      output stall, busy, done, hl_rdata, hi, lo
   );
endinterface

// File: rtl/md_div_iter.sv
// Iterative restoring divider on unsigned magnitudes, DIV_RADIX quotient bits per step.
module md_div_iter #(
   parameter int DATA_W    = 32,
   parameter int DIV_RADIX = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              step_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] quot_o,
   output logic [DATA_W-1:0] rem_o,
   output logic              last_o
);
   localparam int STEPS = DATA_W / DIV_RADIX;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] quo_q;
   logic [DATA_W-1:0] dvs_q;
   logic [CW-1:0]     cnt_q;

   logic [DATA_W-1:0] rem_s [0:DIV_RADIX];
   logic [DATA_W-1:0] quo_s [0:DIV_RADIX];

   assign rem_s[0] = rem_q;
   assign quo_s[0] = quo_q;

   // quo_q shifts dividend bits out the top while quotient bits enter at the bottom
   for (genvar gi = 0; gi < DIV_RADIX; gi++) begin : g_step
      logic [DATA_W:0] trial;
      logic [DATA_W:0] diff;
      assign trial          = {rem_s[gi], quo_s[gi][DATA_W-1]};
      assign diff           = trial - {1'b0, dvs_q};
      assign rem_s[gi+1]    = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
      assign quo_s[gi+1]    = {quo_s[gi][DATA_W-2:0], ~diff[DATA_W]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else if (start_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
         cnt_q <= CW'(STEPS - 1);
      end else if (step_i) begin
         rem_q <= rem_s[DIV_RADIX];
         quo_q <= quo_s[DIV_RADIX];
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign quot_o = quo_q;
   assign rem_o  = rem_q;
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/md_hilo_unit.sv
// EX-stage multiply/divide unit owning HI/LO; stalls HI/LO accesses while an op is in flight.
module md_hilo_unit
   import md_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MUL_LAT   = 2,
   parameter int DIV_RADIX = 1
) (
   input  logic           clk,
   input  logic           rst,
   md_hilo_unit_if.slave  bus
);
   localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   md_state_e         state_q;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic              done_q;
   logic [MCW-1:0]    mul_cnt_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              mul_signed_q;
   logic              qneg_q;
   logic              rneg_q;

   logic              busy;
   logic              accept;
   logic              do_div;
   logic              do_mul;
   logic              do_mt;
   logic              div_zero;
   logic              div_signed;
   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [DATA_W-1:0] div_quot;
   logic [DATA_W-1:0] div_rem;
   logic              div_last;

   logic [2*DATA_W-1:0] ax;
   logic [2*DATA_W-1:0] bx;
   logic [2*DATA_W-1:0] mul_hilo_d;
   logic [DATA_W-1:0]   fix_lo_d;
   logic [DATA_W-1:0]   fix_hi_d;

   assign busy   = (state_q != ST_IDLE);
   assign accept = bus.op_valid & ~busy & ~bus.flush;
   assign do_div = accept & (|bus.div);
   assign do_mul = accept & ~(|bus.div) & (|bus.mult);
   assign do_mt  = accept & ~(|bus.div) & ~(|bus.mult) & (|bus.mthl);

   assign div_zero   = (bus.src_b == '0);
   assign div_signed = pair_signed(bus.div);
   assign a_neg      = div_signed & bus.src_a[DATA_W-1];
   assign b_neg      = div_signed & bus.src_b[DATA_W-1];
   assign a_mag      = a_neg ? -bus.src_a : bus.src_a;
   assign b_mag      = b_neg ? -bus.src_b : bus.src_b;

   md_div_iter #(
      .DATA_W    (DATA_W),
      .DIV_RADIX (DIV_RADIX)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (do_div & ~div_zero),
      .step_i     ((state_q == ST_DIV) & ~bus.flush),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .quot_o     (div_quot),
      .rem_o      (div_rem),
      .last_o     (div_last)
   );

   // Low 2*DATA_W bits of the extended product are exact for both signednesses
   assign ax         = mul_signed_q ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
   assign bx         = mul_signed_q ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
   assign mul_hilo_d = ax * bx;
   assign fix_lo_d   = qneg_q ? -div_quot : div_quot;
   assign fix_hi_d   = rneg_q ? -div_rem  : div_rem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hi_q         <= '0;
         lo_q         <= '0;
         done_q       <= 1'b0;
         mul_cnt_q    <= '0;
         a_q          <= '0;
         b_q          <= '0;
         mul_signed_q <= 1'b0;
         qneg_q       <= 1'b0;
         rneg_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (do_div) begin
                  if (!div_zero) begin
                     state_q <= ST_DIV;
                     qneg_q  <= a_neg ^ b_neg;
                     rneg_q  <= a_neg;
                  end
               end else if (do_mul) begin
                  state_q      <= ST_MUL;
                  a_q          <= bus.src_a;
                  b_q          <= bus.src_b;
                  mul_signed_q <= pair_signed(bus.mult);
                  mul_cnt_q    <= MCW'(MUL_LAT - 1);
               end else if (do_mt) begin
                  if (bus.mthl[HL_HI]) begin
                     hi_q <= bus.src_a;
                  end else if (bus.mthl[HL_LO]) begin
                     lo_q <= bus.src_a;
                  end
               end
            end
            ST_MUL: begin
               if (bus.flush) begin
                  state_q <= ST_IDLE;
               end else if (mul_cnt_q == '0) begin
                  {hi_q, lo_q} <= mul_hilo_d;
                  done_q       <= 1'b1;
                  state_q      <= ST_IDLE;
               end else begin
                  mul_cnt_q <= mul_cnt_q - MCW'(1);
               end
            end
            ST_DIV: begin
               if (bus.flush) begin
                  state_q <= ST_IDLE;
               end else if (div_last) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (!bus.flush) begin
                  lo_q   <= fix_lo_d;
                  hi_q   <= fix_hi_d;
                  done_q <= 1'b1;
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done_q;
   assign bus.stall    = bus.op_valid & busy &
                         ((|bus.mult) | (|bus.div) | (|bus.mthl) | (|bus.mfhl));
   assign bus.hl_rdata = bus.mfhl[HL_HI] ? hi_q : lo_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed bench for md_hilo_unit: expected {HI,LO} queued at issue, popped by a done monitor.
module tb_md_hilo_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   md_hilo_unit_if #(.DATA_W(W)) bus_if ();

   md_hilo_unit #(
      .DATA_W    (W),
      .MUL_LAT   (2),
      .DIV_RADIX (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_pass = 0;
   int n_total = 0;
   int n_done = 0;
   int n_push = 0;
   logic [63:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
         $display("check %-18s got %0h", name, act);
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
      exp_q.push_back({hi, lo});
      n_push++;
   endtask

   task automatic clear_ops();
      bus_if.op_valid = 1'b0;
      bus_if.mult     = '0;
      bus_if.div      = '0;
      bus_if.mthl     = '0;
      bus_if.mfhl     = '0;
      bus_if.src_a    = '0;
      bus_if.src_b    = '0;
      bus_if.flush    = 1'b0;
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for a single cycle; returns just after its accept edge
   task automatic issue(input logic [1:0] m, input logic [1:0] d, input logic [1:0] t,
                        input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      bus_if.op_valid = 1'b1;
      bus_if.mult     = m;
      bus_if.div      = d;
      bus_if.mthl     = t;
      bus_if.mfhl     = f;
      bus_if.src_a    = a;
      bus_if.src_b    = b;
      sync();
      clear_ops();
   endtask

   task automatic busy_len(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus_if.busy !== 1'b1) break;
         n++;
      end
   endtask

   // Scoreboard monitor
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && bus_if.done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
               check("done_unexpected", 64'(bus_if.done), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("hilo_result", {bus_if.hi, bus_if.lo}, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      clear_ops();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_hi",    64'(bus_if.hi),    64'd0);
      check("rst_lo",    64'(bus_if.lo),    64'd0);
      check("rst_busy",  64'(bus_if.busy),  64'd0);
      check("rst_done",  64'(bus_if.done),  64'd0);
      check("rst_stall", 64'(bus_if.stall), 64'd0);
      sync();
      rst = 1'b0;
      sync();

      // MULT -3 x 5
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFF1);
      issue(2'b01, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFD, 32'd5);
      busy_len(n);
      check("mult_busy", 64'(n), 64'd2);
      sync();

      // MULTU 0xFFFFFFFF x 2
      push_exp(32'h0000_0001, 32'hFFFF_FFFE);
      issue(2'b10, 2'b00, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2);
      busy_len(n);
      check("multu_busy", 64'(n), 64'd2);
      sync();

      // DIVU 100 / 7
      push_exp(32'd2, 32'd14);
      issue(2'b00, 2'b10, 2'b00, 2'b00, 32'd100, 32'd7);
      busy_len(n);
      check("divu_busy", 64'(n), 64'd33);
      sync();

      // DIV -7 / 2
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(2'b00, 2'b01, 2'b00, 2'b00, 32'hFFFF_FFF9, 32'd2);
      busy_len(n);
      check("div_neg_busy", 64'(n), 64'd33);
      sync();

      // DIV 0x80000000 / -1 wraps
      push_exp(32'h0000_0000, 32'h8000_0000);
      issue(2'b00, 2'b01, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      busy_len(n);
      check("div_wrap_busy", 64'(n), 64'd33);
      sync();

      // MTHI / MTLO
      issue(2'b00, 2'b00, 2'b10, 2'b00, 32'h11, 32'd0);
      @(negedge clk);
      check("mthi_hi", 64'(bus_if.hi), 64'h11);
      check("mthi_busy", 64'(bus_if.busy), 64'd0);
      sync();
      issue(2'b00, 2'b00, 2'b01, 2'b00, 32'h22, 32'd0);
      @(negedge clk);
      check("mtlo_lo", 64'(bus_if.lo), 64'h22);
      sync();

      // DIV 5 / 0 leaves everything alone
      issue(2'b00, 2'b01, 2'b00, 2'b00, 32'd5, 32'd0);
      busy_len(n);
      check("div0_busy", 64'(n), 64'd0);
      check("div0_hi", 64'(bus_if.hi), 64'h11);
      check("div0_lo", 64'(bus_if.lo), 64'h22);
      sync();

      // A flushed MTHI is not accepted
      bus_if.op_valid = 1'b1;
      bus_if.mthl     = 2'b10;
      bus_if.src_a    = 32'h999;
      bus_if.flush    = 1'b1;
      sync();
      clear_ops();
      @(negedge clk);
      check("flush_mthi_hi", 64'(bus_if.hi), 64'h11);
      sync();

      // MFHI three cycles behind DIVU 100/7, with an ADDU in between
      push_exp(32'd2, 32'd14);
      issue(2'b00, 2'b10, 2'b00, 2'b00, 32'd100, 32'd7);
      bus_if.op_valid = 1'b1;
      @(negedge clk);
      check("addu_stall", 64'(bus_if.stall), 64'd0);
      check("addu_busy", 64'(bus_if.busy), 64'd1);
      sync();
      clear_ops();
      sync();
      sync();
      bus_if.op_valid = 1'b1;
      bus_if.mfhl     = 2'b10;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus_if.stall !== 1'b1) break;
         n++;
      end
      check("mfhi_stall_len", 64'(n), 64'd30);
      check("mfhi_stall_end", 64'(bus_if.stall), 64'd0);
      check("mfhi_rdata", 64'(bus_if.hl_rdata), 64'd2);
      sync();
      clear_ops();

      // Flush in cycle 10 of a divide
      issue(2'b00, 2'b00, 2'b10, 2'b00, 32'h5, 32'd0);
      issue(2'b00, 2'b00, 2'b01, 2'b00, 32'h5, 32'd0);
      issue(2'b00, 2'b10, 2'b00, 2'b00, 32'd100, 32'd7);
      repeat (9) sync();
      bus_if.flush = 1'b1;
      sync();
      bus_if.flush = 1'b0;
      @(negedge clk);
      check("flush_busy", 64'(bus_if.busy), 64'd0);
      check("flush_hi", 64'(bus_if.hi), 64'h5);
      check("flush_lo", 64'(bus_if.lo), 64'h5);
      sync();
      issue(2'b00, 2'b00, 2'b01, 2'b00, 32'hABCD, 32'd0);
      @(negedge clk);
      check("mtlo_after_flush", 64'(bus_if.lo), 64'hABCD);
      repeat (40) @(negedge clk);
      check("flush_hi_late", 64'(bus_if.hi), 64'h5);
      check("flush_lo_late", 64'(bus_if.lo), 64'hABCD);
      sync();

      // Async reset in the middle of a multiply
      issue(2'b01, 2'b00, 2'b00, 2'b00, 32'd7, 32'd9);
      #2;
      rst = 1'b1;
      #1;
      check("arst_hi",   64'(bus_if.hi),   64'd0);
      check("arst_lo",   64'(bus_if.lo),   64'd0);
      check("arst_busy", 64'(bus_if.busy), 64'd0);
      check("arst_done", 64'(bus_if.done), 64'd0);
      sync();
      rst = 1'b0;
      sync();
      push_exp(32'd0, 32'd6);
      issue(2'b01, 2'b00, 2'b00, 2'b00, 32'd2, 32'd3);
      busy_len(n);
      check("mult_after_rst", 64'(n), 64'd2);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("done_count", 64'(n_done), 64'(n_push));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
